// File: rtl/reg_bus_arbiter_pkg.sv
// Shared definitions for the register-bus arbiter: sequencer states, default
// bus geometry and requester port indices.
package reg_bus_arbiter_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 16;

    localparam logic HOST = 1'b0;
    localparam logic DAQ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        ACK
    } state_t;

endpackage

// File: rtl/reg_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the port that was not
// granted last wins. The last-grant state lives in the parent.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_sel
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_sel = ~last_gnt;
        end else begin
            gnt_sel = req1;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared register bus:
// one read or write per grant, then a one-cycle ack back to the requester.
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_write,
    inout  wire  [DATA_W-1:0] bus_data,
    output logic              busy
);

    state_t            state, state_n;
    logic              last_gnt, last_gnt_n;
    logic              sel_q, sel_n;
    logic              we_q, we_n;
    logic              oor_q, oor_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              bus_write_q, bus_write_n;
    logic [1:0]        ack_q, ack_n;
    logic [1:0]        err_q, err_n;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_n [2];

    logic              gnt_valid;
    logic              gnt_sel;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    rr_arb2 u_arb (
        .req0      (req0),
        .req1      (req1),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_sel   (gnt_sel)
    );

    always_comb begin
        req_we    = (gnt_sel == DAQ) ? we1    : we0;
        req_addr  = (gnt_sel == DAQ) ? addr1  : addr0;
        req_wdata = (gnt_sel == DAQ) ? wdata1 : wdata0;
    end

    always_comb begin
        state_n     = state;
        last_gnt_n  = last_gnt;
        sel_n       = sel_q;
        we_n        = we_q;
        oor_n       = oor_q;
        wdata_n     = wdata_q;
        addr_n      = addr_q;
        bus_write_n = 1'b0;
        ack_n       = '0;
        err_n       = '0;
        rdata_n     = rdata_q;

        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    sel_n   = gnt_sel;
                    we_n    = req_we;
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    oor_n   = (int'(req_addr) >= NUM_REGS);
                    state_n = SETUP;
                end
            end
            SETUP: begin
                // Strobe is registered here so it covers exactly the XFER cycle.
                bus_write_n = we_q & ~oor_q;
                state_n     = XFER;
            end
            XFER: begin
                if (!we_q) begin
                    rdata_n[sel_q] = oor_q ? '0 : bus_data;
                end
                ack_n[sel_q] = 1'b1;
                err_n[sel_q] = oor_q;
                state_n      = ACK;
            end
            ACK: begin
                last_gnt_n = sel_q;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            wdata_q     <= '0;
            addr_q      <= '0;
            bus_write_q <= 1'b0;
            ack_q       <= '0;
            err_q       <= '0;
            rdata_q     <= '{default: '0};
        end else begin
            state       <= state_n;
            last_gnt    <= last_gnt_n;
            sel_q       <= sel_n;
            we_q        <= we_n;
            oor_q       <= oor_n;
            wdata_q     <= wdata_n;
            addr_q      <= addr_n;
            bus_write_q <= bus_write_n;
            ack_q       <= ack_n;
            err_q       <= err_n;
            rdata_q     <= rdata_n;
        end
    end

    assign bus_data  = bus_write_q ? wdata_q : 'z;
    assign bus_addr  = addr_q;
    assign bus_write = bus_write_q;
    assign busy      = (state != IDLE);
    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign err0      = err_q[0];
    assign err1      = err_q[1];
    assign rdata0    = rdata_q[0];
    assign rdata1    = rdata_q[1];

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with a small behavioural register bank
// on the shared bus.
module tb_reg_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [4:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic [4:0]  bus_addr;
    logic        bus_write;
    wire  [15:0] bus_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    reg_bus_arbiter #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .rdata0    (rdata0),
        .err0      (err0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata1    (rdata1),
        .err1      (err1),
        .bus_addr  (bus_addr),
        .bus_write (bus_write),
        .bus_data  (bus_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Register bank: samples writes mid-strobe, drives the bus whenever the
    // strobe is low; unimplemented addresses return a marker pattern.
    logic [15:0] mem [16];
    logic [15:0] bank_out;

    assign bank_out = (bus_addr < 5'd16) ? mem[bus_addr[3:0]] : 16'hDEAD;
    assign bus_data = bus_write ? 16'hzzzz : bank_out;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
        end else if (bus_write && bus_addr < 5'd16) begin
            mem[bus_addr[3:0]] <= bus_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Any arbiter drive outside the strobe would corrupt what the bank puts out.
    always @(negedge clk) begin
        if (!reset && !bus_write) chk("bus_release", 32'(bus_data), 32'(bank_out));
    end

    task automatic txn(input string tag, input logic port, input logic w,
                       input logic [4:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input logic exp_err);
        int ack_at = 0;
        int wr_cycles = 0;
        logic ack_s, err_s;
        logic [15:0] rd_s;
        if (port) begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
        else      begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
        for (int c = 1; c <= 20 && ack_at == 0; c++) begin
            @(negedge clk);
            if (bus_write) begin
                wr_cycles++;
                chk({tag, "_bus_addr"}, 32'(bus_addr), 32'(a));
                chk({tag, "_bus_data"}, 32'(bus_data), 32'(d));
            end
            ack_s = port ? ack1 : ack0;
            if (ack_s) begin
                ack_at = c;
                err_s = port ? err1 : err0;
                rd_s  = port ? rdata1 : rdata0;
                chk({tag, "_other_ack"}, 32'(port ? ack0 : ack1), 32'd0);
                chk({tag, "_err"}, 32'(err_s), 32'(exp_err));
                if (!w) chk({tag, "_rdata"}, 32'(rd_s), 32'(exp_rd));
            end
        end
        chk({tag, "_ack_cycle"}, 32'(ack_at), 32'd4);
        chk({tag, "_strobe_cycles"}, 32'(wr_cycles), (w && a < 5'd16) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        if (port) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_drop"}, 32'({ack1, ack0}), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic tie_read(input string tag, input logic [15:0] exp_rd);
        int t0 = 0;
        int t1 = 0;
        we0 = 1'b0; addr0 = 5'h01; we1 = 1'b0; addr1 = 5'h01;
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 1; c <= 20 && (t0 == 0 || t1 == 0); c++) begin
            @(negedge clk);
            if (ack0 || ack1) chk({tag, "_ack_excl"}, 32'(ack0 & ack1), 32'd0);
            if (ack0) begin t0 = c; chk({tag, "_rdata0"}, 32'(rdata0), 32'(exp_rd)); end
            if (ack1) begin t1 = c; chk({tag, "_rdata1"}, 32'(rdata1), 32'(exp_rd)); end
            @(posedge clk); #1;
            if (c == t0) req0 = 1'b0;
            if (c == t1) req1 = 1'b0;
        end
        chk({tag, "_ack0_cycle"}, 32'(t0), 32'd4);
        chk({tag, "_ack1_cycle"}, 32'(t1), 32'd8);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int a1 = 0;
        int a2 = 0;
        int idle_between = 0;
        int seen = 0;

        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ack", 32'({ack1, ack0}), 32'd0);
        chk("rst_err", 32'({err1, err0}), 32'd0);
        chk("rst_rdata", {rdata1, rdata0}, 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_write", 32'(bus_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        txn("wr3", 1'b0, 1'b1, 5'h03, 16'hBEEF, 16'h0000, 1'b0);
        txn("rd3", 1'b0, 1'b0, 5'h03, 16'h0000, 16'hBEEF, 1'b0);

        txn("wr1_p1", 1'b1, 1'b1, 5'h01, 16'h1111, 16'h0000, 1'b0);
        tie_read("tie_a", 16'h1111);
        tie_read("tie_b", 16'h1111);

        // Port 1 held high across its ack: two back-to-back reads.
        we1 = 1'b0; addr1 = 5'h03; req1 = 1'b1;
        for (int c = 1; c <= 20 && seen < 2; c++) begin
            @(negedge clk);
            if (seen == 1 && !busy) idle_between++;
            if (ack1) begin
                seen++;
                if (seen == 1) a1 = c; else a2 = c;
                chk("b2b_rdata1", 32'(rdata1), 32'hBEEF);
            end
            @(posedge clk); #1;
            if (seen == 2) req1 = 1'b0;
        end
        req1 = 1'b0;
        chk("b2b_ack1_first", 32'(a1), 32'd4);
        chk("b2b_ack1_second", 32'(a2), 32'd8);
        chk("b2b_idle_cycles", 32'(idle_between), 32'd1);
        @(posedge clk); #1;

        txn("oor_wr", 1'b0, 1'b1, 5'h12, 16'h1234, 16'h0000, 1'b1);
        txn("oor_rd", 1'b0, 1'b0, 5'h12, 16'h0000, 16'h0000, 1'b1);
        txn("rd3_again", 1'b0, 1'b0, 5'h03, 16'h0000, 16'hBEEF, 1'b0);

        // Reset lands on the edge that ends the write's XFER cycle.
        we0 = 1'b1; addr0 = 5'h05; wdata0 = 16'h5555; req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rstx_strobe_in_xfer", 32'(bus_write), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("rstx_strobe_off", 32'(bus_write), 32'd0);
        chk("rstx_bus_data", 32'(bus_data), 32'(bank_out));
        chk("rstx_no_ack", 32'({ack1, ack0}), 32'd0);
        chk("rstx_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstx_no_ack_late", 32'({ack1, ack0}), 32'd0);
        @(posedge clk); #1;
        txn("rd5_after_rst", 1'b0, 1'b0, 5'h05, 16'h0000, 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
